zone_metering: RTL

- Parametrised successor to the fixed centre/average metering in the camera pipeline.
- Divides a programmable window of the debayered RGB stream into a ZONES_X × ZONES_Y grid of square power-of-two zones.
- Per zone, computes either the RGB average or the RGB peak value, selected per frame.
- Sits beside the existing meters on the debayer output, in the pixel clock domain. Results are read back through a zone-indexed port for auto-exposure and white balance.

---
 rtl/zone_metering.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/zone_metering.sv
// Zone metering: per-zone RGB average or peak over a programmable window of the
// debayered stream, with a zone-indexed registered readout.
module zone_metering #(
   parameter int DATA_WIDTH    = 10,
   parameter int OUT_WIDTH     = 8,
   parameter int ZONES_X       = 4,
   parameter int ZONES_Y       = 4,
   parameter int MAX_ZONE_LOG2 = 7,
   parameter int COORD_WIDTH   = 11
) (
   input  logic                                  clock_in,
   input  logic                                  reset_in,
   input  logic [DATA_WIDTH-1:0]                 red_data_in,
   input  logic [DATA_WIDTH-1:0]                 green_data_in,
   input  logic [DATA_WIDTH-1:0]                 blue_data_in,
   input  logic                                  line_valid_in,
   input  logic                                  frame_valid_in,
   input  logic [COORD_WIDTH-1:0]                x_start_in,
   input  logic [COORD_WIDTH-1:0]                y_start_in,
   input  logic [$clog2(MAX_ZONE_LOG2+1)-1:0]    zone_size_log2_in,
   input  logic                                  peak_mode_in,
   input  logic [$clog2(ZONES_X*ZONES_Y)-1:0]    read_zone_in,
   output logic [OUT_WIDTH-1:0]                  red_metering_out,
   output logic [OUT_WIDTH-1:0]                  green_metering_out,
   output logic [OUT_WIDTH-1:0]                  blue_metering_out,
   output logic                                  metering_ready_out,
   output logic                                  frame_incomplete_out
);

   localparam int ZSW  = $clog2(MAX_ZONE_LOG2+1);
   localparam int NZ   = ZONES_X*ZONES_Y;
   localparam int RZW  = $clog2(NZ);
   localparam int AW   = DATA_WIDTH + 2*MAX_ZONE_LOG2;
   localparam int CXW  = (ZONES_X > 1) ? $clog2(ZONES_X) : 1;
   localparam int CYW  = (ZONES_Y > 1) ? $clog2(ZONES_Y) : 1;
   localparam int RCW  = $clog2(ZONES_Y+1);
   localparam int WW   = COORD_WIDTH + MAX_ZONE_LOG2 + $clog2(ZONES_X+ZONES_Y) + 1;
   localparam int DROP = DATA_WIDTH - OUT_WIDTH;

   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_e;

   state_e                       state_q, state_d;
   logic                         fv_q, lv_q;
   logic                         fv_rise, fv_fall, lv_rise, lv_fall, acc_en;
   logic [COORD_WIDTH-1:0]       xs_q, ys_q;
   logic [ZSW-1:0]               zsz_q;
   logic                         peak_q;
   logic [COORD_WIDTH-1:0]       x_cnt_q, y_q, x_cur;
   logic [RCW-1:0]               trig_cnt_q;
   logic [WW-1:0]                dx, dy, span_x, span_y, mask;
   logic                         in_x, in_y, row_last, trig_now;
   logic [CXW-1:0]               col, pcol_q, wr_col_q;
   logic [CYW-1:0]               row, flush_row_q, wr_row_q;
   logic                         pv_q, flush_q, wr_active_q;
   logic [2:0][DATA_WIDTH-1:0]   pix_q;
   logic [2:0][AW-1:0]           acc_q    [ZONES_X];
   logic [2:0][AW-1:0]           shadow_q [ZONES_X];
   logic [2:0][OUT_WIDTH-1:0]    mem_q    [NZ];
   logic [2:0][OUT_WIDTH-1:0]    wr_data, rd_q;
   logic [RZW-1:0]               wr_idx;
   logic                         ready_q, inc_q;

   assign fv_rise = frame_valid_in & ~fv_q;
   assign fv_fall = ~frame_valid_in & fv_q;
   assign lv_rise = line_valid_in & ~lv_q;
   assign lv_fall = ~line_valid_in & lv_q;
   assign acc_en  = (state_q == ACCUM);

   // Edge history follows the inputs through reset so a frame already running
   // when reset releases is not taken as a new frame start.
   always_ff @(posedge clock_in) begin
      fv_q <= frame_valid_in;
      lv_q <= line_valid_in;
   end

   always_ff @(posedge clock_in) begin
      if (reset_in) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (fv_rise) state_d = ACCUM;
         ACCUM:   if (fv_fall) state_d = DONE;
         DONE:    if (fv_rise) state_d = ACCUM;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock_in) begin
      if (reset_in) begin
         xs_q   <= '0;
         ys_q   <= '0;
         zsz_q  <= '0;
         peak_q <= 1'b0;
      end else if (fv_rise) begin
         xs_q   <= x_start_in;
         ys_q   <= y_start_in;
         zsz_q  <= zone_size_log2_in;
         peak_q <= peak_mode_in;
      end
   end

   always_comb begin
      x_cur    = lv_rise ? '0 : x_cnt_q;
      span_x   = WW'(ZONES_X) << zsz_q;
      span_y   = WW'(ZONES_Y) << zsz_q;
      mask     = (WW'(1) << zsz_q) - WW'(1);
      dx       = WW'(x_cur) - WW'(xs_q);
      dy       = WW'(y_q) - WW'(ys_q);
      in_x     = (x_cur >= xs_q) && (dx < span_x);
      in_y     = (y_q >= ys_q) && (dy < span_y);
      row_last = ((dy & mask) == mask);
      col      = CXW'(dx >> zsz_q);
      row      = CYW'(dy >> zsz_q);
      trig_now = acc_en & lv_fall & in_y & row_last;
   end

   always_ff @(posedge clock_in) begin
      if (reset_in) begin
         x_cnt_q    <= '0;
         y_q        <= '0;
         trig_cnt_q <= '0;
      end else begin
         if (line_valid_in) x_cnt_q <= x_cur + COORD_WIDTH'(1);
         if (fv_rise) begin
            y_q        <= '0;
            trig_cnt_q <= '0;
         end else if (acc_en && lv_fall) begin
            y_q <= y_q + COORD_WIDTH'(1);
            if (trig_now) trig_cnt_q <= trig_cnt_q + RCW'(1);
         end
      end
   end

   // The flush request rides the same register stage as the pixels so the
   // shadow copy sees the line's final pixel already accumulated.
   always_ff @(posedge clock_in) begin
      if (reset_in) begin
         pv_q        <= 1'b0;
         pcol_q      <= '0;
         pix_q       <= '0;
         flush_q     <= 1'b0;
         flush_row_q <= '0;
      end else begin
         pv_q        <= acc_en & line_valid_in & in_x & in_y;
         pcol_q      <= col;
         pix_q       <= {blue_data_in, green_data_in, red_data_in};
         flush_q     <= trig_now;
         flush_row_q <= row;
      end
   end

   always_ff @(posedge clock_in) begin
      if (reset_in || fv_rise || flush_q) begin
         for (int unsigned c = 0; c < ZONES_X; c++) acc_q[c] <= '0;
      end else if (pv_q) begin
         for (int unsigned ch = 0; ch < 3; ch++) begin
            if (peak_q) begin
               if (AW'(pix_q[ch]) > acc_q[pcol_q][ch]) acc_q[pcol_q][ch] <= AW'(pix_q[ch]);
            end else begin
               acc_q[pcol_q][ch] <= acc_q[pcol_q][ch] + AW'(pix_q[ch]);
            end
         end
      end
   end

   always_comb begin
      wr_data = '0;
      for (int unsigned ch = 0; ch < 3; ch++) begin
         if (peak_q) wr_data[ch] = OUT_WIDTH'(shadow_q[wr_col_q][ch] >> DROP);
         else        wr_data[ch] = OUT_WIDTH'(shadow_q[wr_col_q][ch] >> (int'(zsz_q) * 2 + DROP));
      end
   end

   assign wr_idx = RZW'(wr_row_q) * RZW'(ZONES_X) + RZW'(wr_col_q);

   always_ff @(posedge clock_in) begin
      if (reset_in) begin
         for (int unsigned c = 0; c < ZONES_X; c++) shadow_q[c] <= '0;
         for (int unsigned z = 0; z < NZ; z++)      mem_q[z]    <= '0;
         wr_active_q <= 1'b0;
         wr_col_q    <= '0;
         wr_row_q    <= '0;
      end else if (flush_q) begin
         shadow_q    <= acc_q;
         wr_active_q <= 1'b1;
         wr_col_q    <= '0;
         wr_row_q    <= flush_row_q;
      end else if (wr_active_q) begin
         mem_q[wr_idx] <= wr_data;
         wr_col_q      <= wr_col_q + CXW'(1);
         if (wr_col_q == CXW'(ZONES_X-1)) wr_active_q <= 1'b0;
      end
   end

   always_ff @(posedge clock_in) begin
      if (reset_in || fv_rise) begin
         ready_q <= 1'b0;
         inc_q   <= 1'b0;
      end else begin
         if (wr_active_q && !flush_q && wr_col_q == CXW'(ZONES_X-1)
             && wr_row_q == CYW'(ZONES_Y-1))
            ready_q <= 1'b1;
         if (acc_en && fv_fall && (int'(trig_cnt_q) + int'(trig_now) < ZONES_Y))
            inc_q <= 1'b1;
      end
   end

   always_ff @(posedge clock_in) begin
      if (reset_in) rd_q <= '0;
      else          rd_q <= mem_q[read_zone_in];
   end

   assign red_metering_out     = rd_q[0];
   assign green_metering_out   = rd_q[1];
   assign blue_metering_out    = rd_q[2];
   assign metering_ready_out   = ready_q;
   assign frame_incomplete_out = inc_q;

endmodule
